vi_controller: RTL and testbench
================================

# vi_controller

Eight-line vectored interrupt controller for the Altair system: the responder that answers the i8080's interrupt-acknowledge cycle, the opposite end of the CPU's `intr`/`inta_n` handshake. It latches requests from on-chip peripherals (sio, timers), drives `intr` to the CPU, and supplies a one-byte `RST n` opcode on the data bus during acknowledge. It also exposes two I/O ports for mask, enable and status. It sits beside `mc6850` in the top-level read mux and I/O decode.

## Interface
- `RESET_MASK`, 8'hFF: mask register value after reset (1 = line masked).
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `irq`  in  8  request lines from peripherals, synchronous to `clk`, rising-edge sensitive
- `inta_n`  in  1  CPU interrupt-acknowledge, active low
- `rd`  in  1  read strobe for I/O ports (decoded by top level)
- `we`  in  1  write strobe for I/O ports (decoded by top level)
- `addr`  in  1  port select (0 = mask/pending, 1 = control/status)
- `data_in`  in  8  CPU write data
- `data_out`  out  8  registered read data / RST opcode
- `ack_rd`  in  1  CPU read during acknowledge (`rd & ~inta_n`, decoded by top level)
- `intr`  out  1  interrupt request to CPU
- `vec_valid`  out  1  high while `data_out` holds an RST opcode; top level selects `data_out` into `idata`

## Operation
- Edge detect: `irq_q` registers `irq` every clock. A bit of `pending` sets on `irq & ~irq_q`. Requests arriving while masked still set `pending`.
- `active = pending & ~mask`. Priority is fixed: line 7 highest, line 0 lowest. `level` is the index of the highest set bit of `active`.
- `intr = enable & |active & (state == IDLE)`, registered.
- State machine:
  - IDLE: wait for `inta_n` == 0. On its falling edge, latch `level` into `cur_level` and go to ACK.
  - ACK: on each `ack_rd`, `data_out <= 8'hC7 | {cur_level,3'b000}` and `vec_valid <= 1`. On `inta_n` == 1, clear `pending[cur_level]` and go to IDLE. `vec_valid` drops on the same edge.
- If `inta_n` falls while `active` == 0 (spurious), `cur_level` = 7 and the opcode is 8'hFF (RST 7). No pending bit is cleared.
- Port 0:
  - write: `mask <= data_in`
  - read: `pending`
- Port 1:
  - write bit7: `enable`
  - write bit6 = 1: clear all `pending` (self-clearing command)
  - write bits 5:0: ignored
  - read: `{enable, state==ACK, 3'b000, cur_level}`
- Simultaneous events:
  - A new edge on line n in the same cycle that `pending[n]` is cleared: set wins, `pending[n]` = 1.
  - Port 1 clear-all in the same cycle as a new edge: the edge wins for that line.
  - A mask write during ACK does not change `cur_level`.
- Reset values: `pending` = 0, `mask` = RESET_MASK, `enable` = 0, `cur_level` = 0, state = IDLE, `intr` = 0, `vec_valid` = 0, `data_out` = 0, `irq_q` = 0.
- Reset mid-ACK returns to IDLE immediately. No opcode is presented afterwards.

## Timing
- `irq` rising edge to `pending` set: 1 clk. To `intr` high: 2 clk (when enabled and unmasked).
- `ack_rd` or port `rd` asserted in cycle t: `data_out` valid at t+1. This matches the existing synchronous memories and CPU `ce` gating.
- `intr` drops the clock after IDLE→ACK and cannot re-assert until 1 clk after the return to IDLE.
- `data_out` holds its last value when no read is in progress. `rd` and `ack_rd` never occur together; if they do, `ack_rd` has priority.

## Structure
- Shared package `altair_pkg`:
  - `RST_BASE` = 8'hC7
  - port offsets `VI_PORT_MASK` = 0, `VI_PORT_CTRL` = 1
  - state enum `vi_state_t` {IDLE, ACK}
- One natural sub-module: `prio_enc8` (8→3 priority encoder plus `any` flag), used for `level`.

## Test plan
- Reset, write mask 8'h00, write port 1 8'h80, pulse `irq[3]` → `intr` high 2 clk later. Then `inta_n` low + `ack_rd` → `data_out` = 8'hDF, `vec_valid` = 1. Then `inta_n` high → `pending` = 8'h00, `intr` = 0.
- Pulse `irq[1]` and `irq[6]` in the same cycle, mask 0, enabled → first acknowledge returns 8'hF7 (RST 6), second returns 8'hCF (RST 1), then `intr` stays 0.
- Mask 8'h10, pulse `irq[4]` → `intr` stays 0 and port 0 reads 8'h10. Write mask 8'h00 → `intr` high 2 clk later.
- `inta_n` low with `pending` = 0 → `data_out` = 8'hFF on `ack_rd`, and `pending` is unchanged afterwards.
- `irq[2]` edge in the same cycle as the ACK→IDLE clear of line 2 → `pending[2]` = 1 and `intr` re-asserts.
- Assert `reset` during ACK → next clk: state IDLE, `vec_valid` 0, `intr` 0, mask reads 8'hFF, port 1 reads 8'h00.

Source files
------------

// File: rtl/altair_pkg.sv
// Shared Altair definitions: vectored-interrupt port map, FSM states and
// the RST opcode builder used by vi_controller.
package altair_pkg;

    // RST n opcode is 11nnn111; RST 0 is the base value.
    localparam logic [7:0] RST_BASE = 8'hC7;

    // I/O port offsets within the interrupt controller.
    localparam logic VI_PORT_MASK = 1'b0;
    localparam logic VI_PORT_CTRL = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } vi_state_t;

    // Build the RST opcode that vectors the CPU to line lvl.
    function automatic logic [7:0] rst_opcode(input logic [2:0] lvl);
        return RST_BASE | {2'b00, lvl, 3'b000};
    endfunction

endpackage

// File: rtl/vi_controller_if.sv
// CPU-side bus of the vectored interrupt controller: I/O port access,
// interrupt request and interrupt-acknowledge handshake.
interface vi_controller_if;
    logic       inta_n;
    logic       rd;
    logic       we;
    logic       addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       ack_rd;
    logic       intr;
    logic       vec_valid;

    // CPU / top-level decode side
    modport master (
        output inta_n, rd, we, addr, data_in, ack_rd,
        input  data_out, intr, vec_valid
    );

    // Interrupt controller side
    modport slave (
        input  inta_n, rd, we, addr, data_in, ack_rd,
        output data_out, intr, vec_valid
    );
endinterface

// File: rtl/prio_enc8.sv
// Fixed-priority 8-to-3 encoder: bit 7 wins, any flags a non-zero input.
module prio_enc8 (
    input  logic [7:0] req,
    output logic [2:0] idx,
    output logic       any
);

    // Index of the highest set request bit (0 when none set).
    always_comb begin
        idx = 3'd0;
        casez (req)
            8'b1???????: idx = 3'd7;
            8'b01??????: idx = 3'd6;
            8'b001?????: idx = 3'd5;
            8'b0001????: idx = 3'd4;
            8'b00001???: idx = 3'd3;
            8'b000001??: idx = 3'd2;
            8'b0000001?: idx = 3'd1;
            8'b00000001: idx = 3'd0;
            default:     idx = 3'd0;
        endcase
    end

    assign any = |req;

endmodule

// File: rtl/vi_controller.sv
// Eight-line vectored interrupt controller answering the i8080
// interrupt-acknowledge cycle with an RST n opcode.
module vi_controller
    import altair_pkg::*;
#(
    parameter logic [7:0] RESET_MASK = 8'hFF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [7:0]     irq,
    vi_controller_if.slave bus
);

    logic [7:0] irq_q_r;
    logic [7:0] pending_r;
    logic [7:0] mask_r;
    logic       enable_r;
    logic [2:0] cur_level_r;
    logic       spurious_r;
    vi_state_t  state_r;
    logic       inta_q_r;
    logic       intr_r;
    logic       vec_valid_r;
    logic [7:0] data_out_r;

    logic [7:0] rise_s;
    logic [7:0] active_s;
    logic [2:0] level_s;
    logic       any_s;
    logic [2:0] new_level_s;
    logic       inta_fall_s;
    logic       wr_mask_s;
    logic       wr_ctrl_s;
    logic       clr_all_s;
    logic       ack_done_s;
    logic       clr_line_s;
    logic [7:0] clr_vec_s;
    logic [7:0] pending_nx_s;
    logic       ack_hit_s;
    logic [2:0] ack_lvl_s;
    logic [7:0] rd_data_s;

    assign rise_s      = irq & ~irq_q_r;
    assign active_s    = pending_r & ~mask_r;

    prio_enc8 u_prio (
        .req (active_s),
        .idx (level_s),
        .any (any_s)
    );

    // A spurious acknowledge (nothing active) vectors to RST 7.
    assign new_level_s = any_s ? level_s : 3'd7;
    assign inta_fall_s = inta_q_r & ~bus.inta_n;

    assign wr_mask_s   = bus.we & (bus.addr == VI_PORT_MASK);
    assign wr_ctrl_s   = bus.we & (bus.addr == VI_PORT_CTRL);
    assign clr_all_s   = wr_ctrl_s & bus.data_in[6];

    assign ack_done_s  = (state_r == ACK) & bus.inta_n;
    assign clr_line_s  = ack_done_s & ~spurious_r;
    assign clr_vec_s   = clr_line_s ? (8'h01 << cur_level_r) : 8'h00;

    // New edges are ORed in last so a set always beats a same-cycle clear.
    assign pending_nx_s = (clr_all_s ? 8'h00 : (pending_r & ~clr_vec_s)) | rise_s;

    // An acknowledge read is honoured in ACK, or on the very cycle inta_n falls.
    assign ack_hit_s = bus.ack_rd &
                       (((state_r == ACK) & ~bus.inta_n) |
                        ((state_r == IDLE) & inta_fall_s));
    assign ack_lvl_s = (state_r == ACK) ? cur_level_r : new_level_s;

    // Port read data selection.
    always_comb begin
        rd_data_s = 8'h00;
        case (bus.addr)
            VI_PORT_MASK: rd_data_s = pending_r;
            VI_PORT_CTRL: rd_data_s = {enable_r, (state_r == ACK), 3'b000, cur_level_r};
            default:      rd_data_s = 8'h00;
        endcase
    end

    // Request capture, registers, acknowledge FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q_r     <= 8'h00;
            pending_r   <= 8'h00;
            mask_r      <= RESET_MASK;
            enable_r    <= 1'b0;
            cur_level_r <= 3'd0;
            spurious_r  <= 1'b0;
            state_r     <= IDLE;
            inta_q_r    <= 1'b1;
            intr_r      <= 1'b0;
            vec_valid_r <= 1'b0;
            data_out_r  <= 8'h00;
        end else begin
            irq_q_r   <= irq;
            inta_q_r  <= bus.inta_n;
            pending_r <= pending_nx_s;

            if (wr_mask_s) begin
                mask_r <= bus.data_in;
            end else begin
                mask_r <= mask_r;
            end

            if (wr_ctrl_s) begin
                enable_r <= bus.data_in[7];
            end else begin
                enable_r <= enable_r;
            end

            intr_r <= enable_r & any_s & (state_r == IDLE);

            case (state_r)
                IDLE: begin
                    if (inta_fall_s) begin
                        state_r     <= ACK;
                        cur_level_r <= new_level_s;
                        spurious_r  <= ~any_s;
                    end else begin
                        state_r     <= IDLE;
                    end
                end
                ACK: begin
                    if (bus.inta_n) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= ACK;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase

            if (ack_hit_s) begin
                data_out_r  <= rst_opcode(ack_lvl_s);
                vec_valid_r <= 1'b1;
            end else if (ack_done_s) begin
                vec_valid_r <= 1'b0;
            end else if (bus.rd) begin
                data_out_r  <= rd_data_s;
                vec_valid_r <= 1'b0;
            end else begin
                data_out_r  <= data_out_r;
                vec_valid_r <= vec_valid_r;
            end
        end
    end

    assign bus.data_out  = data_out_r;
    assign bus.intr      = intr_r;
    assign bus.vec_valid = vec_valid_r;

endmodule

// File: tb/tb_vi_controller.sv
// Directed bench for vi_controller with a queue scoreboard on data_out.
module tb_vi_controller;
    import altair_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq;

    vi_controller_if bus ();

    vi_controller #(.RESET_MASK(8'hFF)) dut (
        .clk   (clk),
        .reset (reset),
        .irq   (irq),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    string      tag_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [7:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic sb_check();
        logic [7:0] e;
        string      t;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty: observed=%h expected=none", bus.data_out);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk(t, bus.data_out, e);
        end
    endtask

    task automatic port_wr(input logic a, input logic [7:0] d);
        bus.addr = a; bus.data_in = d; bus.we = 1'b1;
        step();
        bus.we = 1'b0;
    endtask

    task automatic port_rd(input logic a, input logic [7:0] exp, input string tag);
        bus.addr = a; bus.rd = 1'b1;
        sb_push(tag, exp);
        step();
        bus.rd = 1'b0;
        sb_check();
    endtask

    task automatic pulse(input logic [7:0] bits);
        irq = bits;
        step();
        irq = 8'h00;
    endtask

    task automatic ack_read(input logic [7:0] exp, input string tag);
        bus.ack_rd = 1'b1;
        sb_push(tag, exp);
        step();
        bus.ack_rd = 1'b0;
        sb_check();
        chk({tag, "_vv"}, {7'd0, bus.vec_valid}, 8'h01);
    endtask

    task automatic chk_intr(input string tag, input logic exp);
        chk(tag, {7'd0, bus.intr}, {7'd0, exp});
    endtask

    initial begin
        reset = 1'b1; irq = 8'h00;
        bus.inta_n = 1'b1; bus.rd = 1'b0; bus.we = 1'b0; bus.addr = 1'b0;
        bus.data_in = 8'h00; bus.ack_rd = 1'b0;
        step(); step();
        reset = 1'b0;
        chk_intr("rst_intr", 1'b0);
        chk("rst_vv", {7'd0, bus.vec_valid}, 8'h00);
        chk("rst_dout", bus.data_out, 8'h00);

        // Single request on line 3
        port_wr(VI_PORT_MASK, 8'h00);
        port_wr(VI_PORT_CTRL, 8'h80);
        pulse(8'h08);
        chk_intr("t1_intr_1clk", 1'b0);
        step();
        chk_intr("t1_intr_2clk", 1'b1);
        bus.inta_n = 1'b0; step();
        ack_read(8'hDF, "t1_vec");
        chk_intr("t1_intr_in_ack", 1'b0);
        bus.inta_n = 1'b1; step();
        chk("t1_vv_drop", {7'd0, bus.vec_valid}, 8'h00);
        chk_intr("t1_intr_after", 1'b0);
        port_rd(VI_PORT_MASK, 8'h00, "t1_pending");
        chk_intr("t1_intr_idle", 1'b0);

        // Two simultaneous requests, priority order
        pulse(8'h42);
        step();
        chk_intr("t2_intr", 1'b1);
        bus.inta_n = 1'b0; step();
        ack_read(8'hF7, "t2_vec6");
        bus.inta_n = 1'b1; step();
        chk_intr("t2_intr_return", 1'b0);
        step();
        chk_intr("t2_intr_reassert", 1'b1);
        bus.inta_n = 1'b0; step();
        ack_read(8'hCF, "t2_vec1");
        bus.inta_n = 1'b1; step(); step(); step();
        chk_intr("t2_intr_done", 1'b0);
        port_rd(VI_PORT_MASK, 8'h00, "t2_pending");

        // Masked request latches, then unmask raises intr
        port_wr(VI_PORT_MASK, 8'h10);
        pulse(8'h10);
        step(); step();
        chk_intr("t3_masked_intr", 1'b0);
        port_rd(VI_PORT_MASK, 8'h10, "t3_pending");
        port_wr(VI_PORT_MASK, 8'h00);
        chk_intr("t3_unmask_1", 1'b0);
        step();
        chk_intr("t3_unmask_2", 1'b1);
        bus.inta_n = 1'b0; step();
        ack_read(8'hE7, "t3_vec4");
        bus.inta_n = 1'b1; step();

        // Spurious acknowledge with only a masked line 7 pending
        port_wr(VI_PORT_MASK, 8'h80);
        pulse(8'h80);
        step();
        chk_intr("t4_intr", 1'b0);
        bus.inta_n = 1'b0; step();
        ack_read(8'hFF, "t4_spurious_vec");
        port_rd(VI_PORT_CTRL, 8'hC7, "t4_status_ack");
        chk("t4_vv_port_rd", {7'd0, bus.vec_valid}, 8'h00);
        bus.inta_n = 1'b1; step();
        port_rd(VI_PORT_MASK, 8'h80, "t4_pending_kept");
        // Clear-all together with a new edge on line 0
        bus.addr = VI_PORT_CTRL; bus.data_in = 8'hC0; bus.we = 1'b1; irq = 8'h01;
        step();
        bus.we = 1'b0; irq = 8'h00;
        port_rd(VI_PORT_MASK, 8'h01, "t4_clrall_edge");
        port_wr(VI_PORT_CTRL, 8'hC0);
        port_rd(VI_PORT_MASK, 8'h00, "t4_clrall");

        // Line 2 edge on the same edge its pending bit is cleared
        port_wr(VI_PORT_MASK, 8'h00);
        pulse(8'h04);
        step();
        chk_intr("t5_intr", 1'b1);
        bus.inta_n = 1'b0; step();
        ack_read(8'hD7, "t5_vec2");
        bus.inta_n = 1'b1; irq = 8'h04;
        step();
        irq = 8'h00;
        chk("t5_vv_drop", {7'd0, bus.vec_valid}, 8'h00);
        chk_intr("t5_intr_return", 1'b0);
        step();
        chk_intr("t5_intr_reassert", 1'b1);
        port_rd(VI_PORT_MASK, 8'h04, "t5_pending");

        // Reset in the middle of an acknowledge
        bus.inta_n = 1'b0; step();
        ack_read(8'hD7, "t6_vec2");
        reset = 1'b1;
        step();
        reset = 1'b0; bus.inta_n = 1'b1;
        chk("t6_vv", {7'd0, bus.vec_valid}, 8'h00);
        chk_intr("t6_intr", 1'b0);
        port_rd(VI_PORT_CTRL, 8'h00, "t6_status");
        port_wr(VI_PORT_CTRL, 8'h80);
        pulse(8'h20);
        step(); step();
        chk_intr("t6_mask_ff", 1'b0);
        port_rd(VI_PORT_MASK, 8'h20, "t6_pending");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
